// File: rtl/sram_bus_arbiter.sv
// Two-master Wishbone arbiter for the shared SRAM slave port.
// Ports: clk_bus/rst_bus, m0_* (fetch) and m1_* (load/store) master
// ports, s_* SRAM slave port, grant_o one-hot current owner.
module sram_bus_arbiter #(
   parameter int unsigned MAX_ACKS = 16,
   parameter int unsigned CNT_W    = 5
) (
   input  logic        clk_bus,
   input  logic        rst_bus,
   input  logic [31:0] m0_adr_i,
   input  logic [31:0] m0_dat_i,
   output logic [31:0] m0_dat_o,
   input  logic [3:0]  m0_sel_i,
   input  logic        m0_we_i,
   input  logic        m0_cyc_i,
   input  logic        m0_stb_i,
   output logic        m0_ack_o,
   output logic        m0_err_o,
   output logic        m0_rty_o,
   input  logic [31:0] m1_adr_i,
   input  logic [31:0] m1_dat_i,
   output logic [31:0] m1_dat_o,
   input  logic [3:0]  m1_sel_i,
   input  logic        m1_we_i,
   input  logic        m1_cyc_i,
   input  logic        m1_stb_i,
   output logic        m1_ack_o,
   output logic        m1_err_o,
   output logic        m1_rty_o,
   output logic [31:0] s_adr_o,
   output logic [31:0] s_dat_o,
   output logic [3:0]  s_sel_o,
   output logic        s_we_o,
   output logic        s_cyc_o,
   output logic        s_stb_o,
   input  logic [31:0] s_dat_i,
   input  logic        s_ack_i,
   input  logic        s_err_i,
   input  logic        s_rty_i,
   output logic [1:0]  grant_o
);

   typedef enum logic [2:0] {
      IDLE, OWN0, OWN1, YIELD0, YIELD1
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_ACKS);
   localparam bit LIMIT_ON = (MAX_ACKS != 0);

   state_t           state, state_nxt;
   logic             last, last_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             req0, req1, at_limit;

   assign req0 = m0_cyc_i & m0_stb_i;
   assign req1 = m1_cyc_i & m1_stb_i;
   assign at_limit = LIMIT_ON && (cnt == CNT_MAX);

   always_ff @(posedge clk_bus) begin
      if (rst_bus) begin
         state <= IDLE;
         last  <= 1'b1;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         last  <= last_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      last_nxt  = last;
      cnt_nxt   = cnt;
      m0_dat_o  = s_dat_i;
      m1_dat_o  = s_dat_i;
      m0_ack_o  = 1'b0;
      m0_err_o  = 1'b0;
      m0_rty_o  = 1'b0;
      m1_ack_o  = 1'b0;
      m1_err_o  = 1'b0;
      m1_rty_o  = 1'b0;
      s_adr_o   = '0;
      s_dat_o   = '0;
      s_sel_o   = '0;
      s_we_o    = 1'b0;
      s_cyc_o   = 1'b0;
      s_stb_o   = 1'b0;
      grant_o   = 2'b00;
      unique case (state)
         IDLE: begin
            // On a tie, the master that did not own the bus last wins.
            if (req0 && (!req1 || last)) begin
               state_nxt = OWN0;
               last_nxt  = 1'b0;
               cnt_nxt   = '0;
            end else if (req1) begin
               state_nxt = OWN1;
               last_nxt  = 1'b1;
               cnt_nxt   = '0;
            end
         end
         OWN0: begin
            grant_o  = 2'b01;
            s_adr_o  = m0_adr_i;
            s_dat_o  = m0_dat_i;
            s_sel_o  = m0_sel_i;
            s_we_o   = m0_we_i;
            s_cyc_o  = m0_cyc_i;
            s_stb_o  = m0_stb_i;
            m0_ack_o = s_ack_i;
            m0_err_o = s_err_i;
            m0_rty_o = s_rty_i;
            if (s_ack_i && (cnt != CNT_MAX))
               cnt_nxt = cnt + 1'b1;
            // Only yield outside an ack cycle so no response is dropped.
            if (!m0_cyc_i)
               state_nxt = IDLE;
            else if (at_limit && req1 && !s_ack_i)
               state_nxt = YIELD0;
         end
         OWN1: begin
            grant_o  = 2'b10;
            s_adr_o  = m1_adr_i;
            s_dat_o  = m1_dat_i;
            s_sel_o  = m1_sel_i;
            s_we_o   = m1_we_i;
            s_cyc_o  = m1_cyc_i;
            s_stb_o  = m1_stb_i;
            m1_ack_o = s_ack_i;
            m1_err_o = s_err_i;
            m1_rty_o = s_rty_i;
            if (s_ack_i && (cnt != CNT_MAX))
               cnt_nxt = cnt + 1'b1;
            if (!m1_cyc_i)
               state_nxt = IDLE;
            else if (at_limit && req0 && !s_ack_i)
               state_nxt = YIELD1;
         end
         YIELD0: begin
            grant_o  = 2'b01;
            m0_rty_o = req0;
            if (!m0_cyc_i)
               state_nxt = IDLE;
         end
         YIELD1: begin
            grant_o  = 2'b10;
            m1_rty_o = req1;
            if (!m1_cyc_i)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed bench for sram_bus_arbiter: instance a has a fairness limit
// of 4 acks, instance b has the limit disabled; both share master stimulus.
module tb_sram_bus_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat;
   logic [3:0]  m0_sel, m1_sel;
   logic        m0_we, m0_cyc, m0_stb, m1_we, m1_cyc, m1_stb;

   logic [31:0] a_m0_rdat, a_m1_rdat, a_s_adr, a_s_wdat;
   logic [3:0]  a_s_sel;
   logic        a_s_we, a_s_cyc, a_s_stb;
   logic        a_m0_ack, a_m0_err, a_m0_rty, a_m1_ack, a_m1_err, a_m1_rty;
   logic [1:0]  a_grant;
   logic [31:0] a_sdat = '0;
   logic        a_sack = 1'b0;

   logic [31:0] b_m0_rdat, b_m1_rdat, b_s_adr, b_s_wdat;
   logic [3:0]  b_s_sel;
   logic        b_s_we, b_s_cyc, b_s_stb;
   logic        b_m0_ack, b_m0_err, b_m0_rty, b_m1_ack, b_m1_err, b_m1_rty;
   logic [1:0]  b_grant;
   logic [31:0] b_sdat = '0;
   logic        b_sack = 1'b0;

   int n_assert = 0;
   int n_fail   = 0;
   logic [31:0] q0[$];
   logic [31:0] q1[$];

   sram_bus_arbiter #(.MAX_ACKS(4), .CNT_W(5)) dut_a (
      .clk_bus(clk), .rst_bus(rst),
      .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_dat_o(a_m0_rdat),
      .m0_sel_i(m0_sel), .m0_we_i(m0_we), .m0_cyc_i(m0_cyc),
      .m0_stb_i(m0_stb), .m0_ack_o(a_m0_ack), .m0_err_o(a_m0_err),
      .m0_rty_o(a_m0_rty),
      .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_dat_o(a_m1_rdat),
      .m1_sel_i(m1_sel), .m1_we_i(m1_we), .m1_cyc_i(m1_cyc),
      .m1_stb_i(m1_stb), .m1_ack_o(a_m1_ack), .m1_err_o(a_m1_err),
      .m1_rty_o(a_m1_rty),
      .s_adr_o(a_s_adr), .s_dat_o(a_s_wdat), .s_sel_o(a_s_sel),
      .s_we_o(a_s_we), .s_cyc_o(a_s_cyc), .s_stb_o(a_s_stb),
      .s_dat_i(a_sdat), .s_ack_i(a_sack), .s_err_i(1'b0), .s_rty_i(1'b0),
      .grant_o(a_grant)
   );

   sram_bus_arbiter #(.MAX_ACKS(0), .CNT_W(5)) dut_b (
      .clk_bus(clk), .rst_bus(rst),
      .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_dat_o(b_m0_rdat),
      .m0_sel_i(m0_sel), .m0_we_i(m0_we), .m0_cyc_i(m0_cyc),
      .m0_stb_i(m0_stb), .m0_ack_o(b_m0_ack), .m0_err_o(b_m0_err),
      .m0_rty_o(b_m0_rty),
      .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_dat_o(b_m1_rdat),
      .m1_sel_i(m1_sel), .m1_we_i(m1_we), .m1_cyc_i(m1_cyc),
      .m1_stb_i(m1_stb), .m1_ack_o(b_m1_ack), .m1_err_o(b_m1_err),
      .m1_rty_o(b_m1_rty),
      .s_adr_o(b_s_adr), .s_dat_o(b_s_wdat), .s_sel_o(b_s_sel),
      .s_we_o(b_s_we), .s_cyc_o(b_s_cyc), .s_stb_o(b_s_stb),
      .s_dat_i(b_sdat), .s_ack_i(b_sack), .s_err_i(1'b0), .s_rty_i(1'b0),
      .grant_o(b_grant)
   );

   function automatic logic [31:0] rd_model(input logic [31:0] a);
      return (a == 32'h10) ? 32'hDEADBEEF : {a[15:0], ~a[15:0]};
   endfunction

   // SRAM slave models: classic registered ack one cycle after strobe.
   always @(posedge clk) begin
      a_sack <= (a_s_cyc === 1'b1) && (a_s_stb === 1'b1) && !a_sack;
      if ((a_s_cyc === 1'b1) && (a_s_stb === 1'b1) && !a_sack)
         a_sdat <= rd_model(a_s_adr);
      b_sack <= (b_s_cyc === 1'b1) && (b_s_stb === 1'b1) && !b_sack;
      if ((b_s_cyc === 1'b1) && (b_s_stb === 1'b1) && !b_sack)
         b_sdat <= rd_model(b_s_adr);
   end

   function automatic logic ack_of(input int d, input int m);
      case ({d[0], m[0]})
         2'b00:   return a_m0_ack;
         2'b01:   return a_m1_ack;
         2'b10:   return b_m0_ack;
         default: return b_m1_ack;
      endcase
   endfunction

   function automatic logic rty_of(input int d, input int m);
      case ({d[0], m[0]})
         2'b00:   return a_m0_rty;
         2'b01:   return a_m1_rty;
         2'b10:   return b_m0_rty;
         default: return b_m1_rty;
      endcase
   endfunction

   function automatic logic [31:0] dat_of(input int d, input int m);
      case ({d[0], m[0]})
         2'b00:   return a_m0_rdat;
         2'b01:   return a_m1_rdat;
         2'b10:   return b_m0_rdat;
         default: return b_m1_rdat;
      endcase
   endfunction

   task automatic chk32(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk2(input string tag, input logic [1:0] obs,
                       input logic [1:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input int m, input logic [31:0] adr, input logic we,
                        input logic [31:0] wd, input logic [3:0] sel);
      if (m == 0) begin
         m0_adr = adr; m0_dat = wd; m0_sel = sel; m0_we = we;
         m0_cyc = 1'b1; m0_stb = 1'b1;
         if (!we) q0.push_back(rd_model(adr));
      end else begin
         m1_adr = adr; m1_dat = wd; m1_sel = sel; m1_we = we;
         m1_cyc = 1'b1; m1_stb = 1'b1;
         if (!we) q1.push_back(rd_model(adr));
      end
   endtask

   task automatic drop(input int m);
      if (m == 0) begin
         m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0;
      end else begin
         m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0;
      end
   endtask

   // res: 1 = ack (read data checked against scoreboard), 2 = rty, 0 = none
   task automatic wait_resp(input int d, input int m, output int res);
      logic [31:0] e;
      logic we;
      res = 0;
      we = (m == 0) ? m0_we : m1_we;
      for (int i = 0; i < 30 && res == 0; i++) begin
         tick();
         if (ack_of(d, m)) begin
            res = 1;
            if (!we) begin
               e = 'x;
               if (m == 0 && q0.size() > 0) e = q0.pop_front();
               if (m == 1 && q1.size() > 0) e = q1.pop_front();
               chk32($sformatf("d%0d m%0d rdata", d, m), dat_of(d, m), e);
            end
         end else if (rty_of(d, m)) begin
            res = 2;
            if (!we && m == 0 && q0.size() > 0) void'(q0.pop_back());
            if (!we && m == 1 && q1.size() > 0) void'(q1.pop_back());
         end
      end
      if (res == 0)
         chk1($sformatf("d%0d m%0d response timeout", d, m), ack_of(d, m), 1'b1);
   endtask

   initial begin
      int res;
      rst = 1'b1;
      m0_adr = '0; m0_dat = '0; m0_sel = '0; m0_we = 1'b0;
      m0_cyc = 1'b0; m0_stb = 1'b0;
      m1_adr = '0; m1_dat = '0; m1_sel = '0; m1_we = 1'b0;
      m1_cyc = 1'b0; m1_stb = 1'b0;
      tick(); tick(); tick();

      chk2("reset grant", a_grant, 2'b00);
      chk1("reset s_cyc", a_s_cyc, 1'b0);
      chk1("reset s_stb", a_s_stb, 1'b0);
      chk1("reset m0_ack", a_m0_ack, 1'b0);
      chk1("reset m1_ack", a_m1_ack, 1'b0);
      chk1("reset m0_rty", a_m0_rty, 1'b0);
      chk1("reset m1_err", a_m1_err, 1'b0);
      chk2("reset grant b", b_grant, 2'b00);
      rst = 1'b0;
      tick();

      // simultaneous requests: m0 first, then m1, then m0 again
      issue(0, 32'h20, 1'b0, '0, 4'hF);
      issue(1, 32'h30, 1'b0, '0, 4'hF);
      tick();
      chk2("tie1 grant m0", a_grant, 2'b01);
      wait_resp(0, 0, res);
      chk32("tie1 m0 res", res, 1);
      drop(0);
      tick();
      chk2("tie1 idle gap", a_grant, 2'b00);
      tick();
      chk2("tie1 grant m1", a_grant, 2'b10);
      wait_resp(0, 1, res);
      chk32("tie1 m1 res", res, 1);
      drop(1);
      tick();
      issue(0, 32'h40, 1'b0, '0, 4'hF);
      issue(1, 32'h50, 1'b0, '0, 4'hF);
      tick();
      chk2("tie2 grant m0", a_grant, 2'b01);
      wait_resp(0, 0, res);
      drop(0);
      tick(); tick();
      chk2("tie2 grant m1", a_grant, 2'b10);
      wait_resp(0, 1, res);
      chk32("tie2 m1 res", res, 1);
      drop(1);
      tick(); tick();

      // single master read
      issue(0, 32'h10, 1'b0, '0, 4'hF);
      chk2("single latency grant", a_grant, 2'b00);
      chk1("single latency stb", a_s_stb, 1'b0);
      tick();
      chk2("single grant", a_grant, 2'b01);
      chk32("single s_adr", a_s_adr, 32'h10);
      wait_resp(0, 0, res);
      chk32("single rdata", a_m0_rdat, 32'hDEADBEEF);
      chk1("single m1_ack", a_m1_ack, 1'b0);
      drop(0);
      tick();
      chk1("single ack pulse", a_m0_ack, 1'b0);
      tick();

      // write pass-through
      issue(1, 32'h104, 1'b1, 32'hCAFE0001, 4'b0011);
      tick();
      chk1("wr s_we", a_s_we, 1'b1);
      chk32("wr s_dat", a_s_wdat, 32'hCAFE0001);
      chk32("wr s_adr", a_s_adr, 32'h104);
      chk32("wr s_sel", {28'd0, a_s_sel}, 32'h3);
      wait_resp(0, 1, res);
      chk32("wr ack", res, 1);
      drop(1);
      tick();
      chk1("wr ack pulse", a_m1_ack, 1'b0);
      tick();

      // fairness on instance a (limit 4)
      issue(0, 32'h1000, 1'b0, '0, 4'hF);
      tick();
      issue(1, 32'h2000, 1'b0, '0, 4'hF);
      for (int k = 0; k < 4; k++) begin
         wait_resp(0, 0, res);
         chk32($sformatf("fair ack %0d", k), res, 1);
         issue(0, 32'h1004 + 32'(4 * k), 1'b0, '0, 4'hF);
      end
      wait_resp(0, 0, res);
      chk32("fair rty", res, 2);
      chk2("fair yield grant", a_grant, 2'b01);
      chk1("fair yield stb", a_s_stb, 1'b0);
      chk1("fair yield m0_rty", a_m0_rty, 1'b1);
      drop(0);
      tick(); tick();
      chk2("fair m1 granted", a_grant, 2'b10);
      wait_resp(0, 1, res);
      chk32("fair m1 res", res, 1);
      drop(1);
      tick(); tick();

      // limit disabled on instance b: 40 accesses, no rty
      issue(0, 32'h3000, 1'b0, '0, 4'hF);
      tick();
      issue(1, 32'h4000, 1'b0, '0, 4'hF);
      for (int k = 0; k < 40; k++) begin
         wait_resp(1, 0, res);
         chk32($sformatf("nolim ack %0d", k), res, 1);
         chk2($sformatf("nolim grant %0d", k), b_grant, 2'b01);
         if (k < 39) issue(0, 32'h3004 + 32'(4 * k), 1'b0, '0, 4'hF);
      end
      drop(0);
      tick(); tick();
      chk2("nolim m1 granted", b_grant, 2'b10);
      wait_resp(1, 1, res);
      chk32("nolim m1 res", res, 1);
      drop(1);
      tick(); tick();

      // reset while m1 owns with a slave ack in flight
      issue(1, 32'h60, 1'b0, '0, 4'hF);
      tick();
      chk2("rst pre grant", a_grant, 2'b10);
      chk1("rst pre stb", a_s_stb, 1'b1);
      rst = 1'b1;
      tick();
      chk2("rst grant", a_grant, 2'b00);
      chk1("rst late ack m1", a_m1_ack, 1'b0);
      chk1("rst late ack m0", a_m0_ack, 1'b0);
      chk1("rst late ack b m1", b_m1_ack, 1'b0);
      rst = 1'b0;
      drop(1);
      q1.delete();
      tick(); tick();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
